// File: rtl/up_timer_if.sv
// Control/status bundle for the up-counting interval timer.
// The master drives start/stop/en/limit and observes q/busy/done.
interface up_timer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             en;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (output start, stop, en, limit, input q, busy, done);
    modport slave  (input start, stop, en, limit, output q, busy, done);
endinterface

// File: rtl/up_timer_counter.sv
// Loadable up-counting interval timer: counts 0 -> latched limit on enabled
// cycles while running, then pulses done for one cycle.
module up_timer_counter #(
    parameter int WIDTH = 4
) (
    input logic        clk,
    input logic        reset,
    up_timer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] lim_r;
    logic [WIDTH-1:0] q_inc;
    logic             busy;
    logic             done;

    // q never exceeds lim_r, so the increment cannot wrap when it is used.
    assign q_inc = q + ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q     <= ZERO;
            lim_r <= ZERO;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (bus.en) begin
                        q <= q_inc;
                        if (q_inc == lim_r) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                // IDLE and DONE both accept a start; DONE otherwise falls back to IDLE.
                IDLE, DONE: begin
                    if (bus.start) begin
                        lim_r <= bus.limit;
                        q     <= ZERO;
                        if (bus.limit != ZERO) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_up_timer_counter.sv
// Bench for up_timer_counter: directed vector table, then randomized traffic
// against a remaining-count reference model.
module tb_up_timer_counter;
    localparam int WIDTH = 4;

    logic clk;
    logic reset;

    up_timer_if #(.WIDTH(WIDTH)) bus ();

    up_timer_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       st;
        logic       sp;
        logic       en;
        logic [3:0] lim;
        logic [3:0] q;
        logic       b;
        logic       d;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    function automatic void add(input string name, input logic rst, input logic st,
                                input logic sp, input logic en, input logic [3:0] lim,
                                input logic [3:0] q, input logic b, input logic d);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.en = en; v.lim = lim;
        v.q = q; v.b = b; v.d = d; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic apply(input logic rst, input logic st, input logic sp,
                         input logic en, input logic [3:0] lim);
        @(negedge clk);
        reset     = rst;
        bus.start = st;
        bus.stop  = sp;
        bus.en    = en;
        bus.limit = lim;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] q_e,
                         input logic b_e, input logic d_e);
        total++;
        if (bus.q === q_e && bus.busy === b_e && bus.done === d_e)
            passed++;
        else
            $display("FAIL %s: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                     name, bus.q, bus.busy, bus.done, q_e, b_e, d_e);
    endtask

    // Reference: a run is described by its limit and the enabled cycles still
    // left; the visible count is simply limit - left.
    int m_lim, m_left;
    bit m_run, m_done;

    task automatic model_step(input logic rst, input logic st, input logic sp,
                              input logic en, input logic [3:0] lim);
        if (rst) begin
            m_lim = 0; m_left = 0; m_run = 0; m_done = 0;
        end else if (m_run) begin
            m_done = 0;
            if (sp) m_run = 0;
            else if (en) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_run = 0; m_done = 1; end
            end
        end else if (st) begin
            m_lim = int'(lim); m_left = int'(lim);
            m_run = (m_left > 0); m_done = (m_left == 0);
        end else begin
            m_done = 0;
        end
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0; bus.limit = '0;

        // reset with start held
        add("reset0", 1, 1, 0, 0, 4'd5, 4'd0, 0, 0);
        add("reset1", 1, 1, 0, 0, 4'd5, 4'd0, 0, 0);
        // basic limit=5
        add("basic_start", 0, 1, 0, 1, 4'd5, 4'd0, 1, 0);
        for (int i = 1; i <= 4; i++) add("basic_cnt", 0, 0, 0, 1, 4'd0, 4'(i), 1, 0);
        add("basic_done", 0, 0, 0, 1, 4'd0, 4'd5, 0, 1);
        add("basic_idle", 0, 0, 0, 1, 4'd0, 4'd5, 0, 0);
        // enable gaps, limit change during run ignored
        add("gap_start", 0, 1, 0, 0, 4'd3, 4'd0, 1, 0);
        add("gap_e1",    0, 0, 0, 1, 4'd9, 4'd1, 1, 0);
        add("gap_e0",    0, 0, 0, 0, 4'd0, 4'd1, 1, 0);
        add("gap_e1b",   0, 0, 0, 1, 4'd0, 4'd2, 1, 0);
        add("gap_e0b",   0, 0, 0, 0, 4'd0, 4'd2, 1, 0);
        add("gap_done",  0, 0, 0, 1, 4'd0, 4'd3, 0, 1);
        add("gap_idle",  0, 0, 0, 0, 4'd0, 4'd3, 0, 0);
        // abort via stop, then via reset
        add("abort_start", 0, 1, 0, 1, 4'd10, 4'd0, 1, 0);
        for (int i = 1; i <= 4; i++) add("abort_cnt", 0, 0, 0, 1, 4'd0, 4'(i), 1, 0);
        add("abort_stop",  0, 0, 1, 1, 4'd0, 4'd4, 0, 0);
        add("idle_en",     0, 0, 0, 1, 4'd0, 4'd4, 0, 0);
        add("idle_stop",   0, 0, 1, 0, 4'd0, 4'd4, 0, 0);
        add("rabort_start", 0, 1, 0, 1, 4'd10, 4'd0, 1, 0);
        for (int i = 1; i <= 6; i++) add("rabort_cnt", 0, 0, 0, 1, 4'd0, 4'(i), 1, 0);
        add("rabort_rst",  1, 0, 0, 1, 4'd0, 4'd0, 0, 0);
        add("rabort_post", 0, 0, 0, 1, 4'd0, 4'd0, 0, 0);
        // limit=0 finishes immediately
        add("zero_start", 0, 1, 0, 0, 4'd0, 4'd0, 0, 1);
        add("zero_idle",  0, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        // full range, with a start mid-run that must be ignored
        add("full_start", 0, 1, 0, 1, 4'd15, 4'd0, 1, 0);
        for (int i = 1; i <= 14; i++)
            add("full_cnt", 0, (i == 7), 0, 1, (i == 7) ? 4'd2 : 4'd0, 4'(i), 1, 0);
        add("full_done", 0, 0, 0, 1, 4'd0, 4'd15, 0, 1);
        add("full_idle", 0, 0, 0, 1, 4'd0, 4'd15, 0, 0);
        // back-to-back restart in the DONE cycle
        add("b2b_start",   0, 1, 0, 1, 4'd1, 4'd0, 1, 0);
        add("b2b_done1",   0, 0, 0, 1, 4'd0, 4'd1, 0, 1);
        add("b2b_restart", 0, 1, 0, 1, 4'd2, 4'd0, 1, 0);
        add("b2b_cnt",     0, 0, 0, 1, 4'd0, 4'd1, 1, 0);
        add("b2b_done2",   0, 0, 0, 1, 4'd0, 4'd2, 0, 1);
        add("b2b_idle",    0, 0, 0, 1, 4'd0, 4'd2, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].lim);
            check(vecs[i].name, vecs[i].q, vecs[i].b, vecs[i].d);
        end

        // randomized traffic against the reference model
        apply(1, 0, 0, 0, 4'd0);
        model_step(1, 0, 0, 0, 4'd0);
        check("rand_reset", 4'(m_lim - m_left), m_run, m_done);
        for (int n = 0; n < 3000; n++) begin
            logic       r_rst, r_st, r_sp, r_en;
            logic [3:0] r_lim;
            r_rst = ($urandom_range(0, 99) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_sp  = ($urandom_range(0, 19) == 0);
            r_en  = ($urandom_range(0, 2) != 0);
            r_lim = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 4));
            apply(r_rst, r_st, r_sp, r_en, r_lim);
            model_step(r_rst, r_st, r_sp, r_en, r_lim);
            check("rand", 4'(m_lim - m_left), m_run, m_done);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
